jk_register_bank: RTL and testbench

- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit bank of JK flip-flops sharing one clock.
- A mode select reuses the bank as one of four functions:
  - independent per-bit JK register;
  - synchronous up counter;
  - synchronous down counter;
  - serial shift register.
- Counter and shifter modes drive the internal J/K inputs of each flop from logic, so all state lives in JK cells.
- Used as the general sequential building block for later chapter-2 exercises.

---
 rtl/jk_register_bank.sv | 139 +++++++++++++
 tb/tb_jk_register_bank.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_register_bank.sv
// -----------------------------------------------------------------------------
// jk_register_bank
//
// A WIDTH-bit bank of JK flip-flops on a single clock. A two-bit mode select
// turns the bank into one of four functions, and in every mode the state is
// updated only through the JK cell equation. Counter and shifter modes build
// each cell's J/K inputs from the current state.
//
//   mode 00 : independent JK register (J/K taken from j/k)
//   mode 01 : synchronous up counter   (q <= q + 1)
//   mode 10 : synchronous down counter (q <= q - 1)
//   mode 11 : shift left               (q <= {q[WIDTH-2:0], ser_in})
//
// Parameters
//   WIDTH     number of flip-flops, 2..32
//   RESET_VAL value forced onto q while rst is high
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   en       in   1      global enable; 0 holds the bank in every mode
//   mode     in   2      function select (see above)
//   j, k     in   WIDTH  per-bit J/K, used only in mode 00
//   ser_in   in   1      serial input, used only in mode 11
//   q        out  WIDTH  flip-flop state
//   ser_out  out  1      q[WIDTH-1]
//   tc       out  1      combinational terminal count: next edge wraps
// -----------------------------------------------------------------------------
module jk_register_bank #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] j_int;
  logic [WIDTH-1:0] k_int;
  logic [WIDTH-1:0] up_toggle;
  logic [WIDTH-1:0] dn_toggle;
  logic [WIDTH-1:0] shift_src;

  // Per-bit JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic [WIDTH-1:0] jk_next(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] jv,
    input logic [WIDTH-1:0] kv
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    for (int i = 0; i < WIDTH; i++) begin
      case ({jv[i], kv[i]})
        2'b00:   nxt[i] = cur[i];
        2'b01:   nxt[i] = 1'b0;
        2'b10:   nxt[i] = 1'b1;
        default: nxt[i] = ~cur[i];
      endcase
    end
    return nxt;
  endfunction

  // Toggle enables for the counters. Bit i toggles when every lower bit is
  // one (up) or zero (down). Each term is computed from q_q through a mask
  // rather than a ripple chain so no signal depends on itself.
  always_comb begin
    logic [WIDTH-1:0] lower_mask;
    up_toggle = '0;
    dn_toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lower_mask   = (WIDTH'(1) << i) - WIDTH'(1);
      up_toggle[i] = &(q_q | ~lower_mask);
      dn_toggle[i] = &(~q_q | ~lower_mask);
    end
  end

  assign shift_src = {q_q[WIDTH-2:0], ser_in};

  // J/K steering. With en low every cell sees JK=00 and holds.
  always_comb begin
    j_int = '0;
    k_int = '0;
    if (en) begin
      case (mode_e'(mode))
        MODE_JK: begin
          j_int = j;
          k_int = k;
        end
        MODE_UP: begin
          j_int = up_toggle;
          k_int = up_toggle;
        end
        MODE_DOWN: begin
          j_int = dn_toggle;
          k_int = dn_toggle;
        end
        default: begin
          // Shift: J=d, K=~d makes each cell behave as a D flop.
          j_int = shift_src;
          k_int = ~shift_src;
        end
      endcase
    end
  end

  assign q_d = jk_next(q_q, j_int, k_int);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign ser_out = q_q[WIDTH-1];

  // Flags that the coming edge wraps the counter in its current direction.
  assign tc = en & (((mode == MODE_UP)   & (&q_q)) |
                    ((mode == MODE_DOWN) & ~(|q_q)));

endmodule

// File: tb/tb_jk_register_bank.sv
module tb_jk_register_bank;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         ser_in;
  logic [W-1:0] q;
  logic         ser_out;
  logic         tc;

  int compared;
  int mismatched;

  jk_register_bank #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .ser_in  (ser_in),
    .q       (q),
    .ser_out (ser_out),
    .tc      (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges, then released.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  // Reference model: behaviour stated as arithmetic on the whole word.
  function automatic logic [W-1:0] model_next(
    input logic [W-1:0] cur, input logic e, input logic [1:0] m,
    input logic [W-1:0] jv, input logic [W-1:0] kv, input logic s);
    int v;
    logic [W-1:0] r;
    if (!e) return cur;
    case (m)
      2'd1: begin v = (int'(cur) + 1) % (1 << W); r = W'(v); end
      2'd2: begin v = (int'(cur) + (1 << W) - 1) % (1 << W); r = W'(v); end
      2'd3: r = {cur[W-2:0], s};
      default: begin
        r = cur;
        for (int b = 0; b < W; b++) begin
          if (jv[b] && kv[b])       r[b] = ~cur[b];
          else if (jv[b])           r[b] = 1'b1;
          else if (kv[b])           r[b] = 1'b0;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic model_tc(input logic [W-1:0] cur, input logic e, input logic [1:0] m);
    return e && ((m == 2'd1 && cur == {W{1'b1}}) || (m == 2'd2 && cur == '0));
  endfunction

  task automatic test_reset();
    tick();
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (q !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_async q: got %b expected %b", q, 4'b0000);
    end
    compared++;
    if (ser_out !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_async ser_out: got %b expected 0", ser_out);
    end
    compared++;
    if (tc !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_async tc: got %b expected 0", tc);
    end
    tick();
    rst = 1'b0;
    en = 1'b0;
    mode = 2'b01;
    j = 4'b1111;
    k = 4'b0000;
    for (int n = 0; n < 3; n++) tick();
    compared++;
    if (q !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_en_hold q: got %b expected %b", q, 4'b0000);
    end
  endtask

  task automatic test_jk_mode();
    en = 1'b1;
    mode = 2'b00;
    j = 4'b1010;
    k = 4'b0101;
    tick();
    compared++;
    if (q !== 4'b1010) begin
      mismatched++;
      $display("FAIL jk_setclr q: got %b expected %b", q, 4'b1010);
    end
    j = 4'b1111;
    k = 4'b1111;
    tick();
    compared++;
    if (q !== 4'b0101) begin
      mismatched++;
      $display("FAIL jk_toggle q: got %b expected %b", q, 4'b0101);
    end
    j = 4'b0000;
    k = 4'b0000;
    tick();
    tick();
    compared++;
    if (q !== 4'b0101) begin
      mismatched++;
      $display("FAIL jk_hold q: got %b expected %b", q, 4'b0101);
    end
  endtask

  task automatic test_up_count();
    do_reset();
    en = 1'b1;
    mode = 2'b01;
    for (int n = 1; n <= 15; n++) begin
      tick();
      compared++;
      if (q !== W'(n)) begin
        mismatched++;
        $display("FAIL up_step q: got %b expected %b", q, W'(n));
      end
    end
    compared++;
    if (tc !== 1'b1) begin
      mismatched++;
      $display("FAIL up_tc_at_max tc: got %b expected 1", tc);
    end
    tick();
    compared++;
    if (q !== 4'b0000 || tc !== 1'b0) begin
      mismatched++;
      $display("FAIL up_wrap q/tc: got %b/%b expected 0000/0", q, tc);
    end
    en = 1'b0;
    tick();
    tick();
    compared++;
    if (q !== 4'b0000) begin
      mismatched++;
      $display("FAIL up_en_hold q: got %b expected 0000", q);
    end
  endtask

  task automatic test_down_count();
    do_reset();
    en = 1'b1;
    mode = 2'b10;
    #1;
    compared++;
    if (tc !== 1'b1) begin
      mismatched++;
      $display("FAIL down_tc_at_zero tc: got %b expected 1", tc);
    end
    tick();
    compared++;
    if (q !== 4'b1111) begin
      mismatched++;
      $display("FAIL down_wrap q: got %b expected 1111", q);
    end
    for (int n = 0; n < 3; n++) tick();
    compared++;
    if (q !== 4'b1100) begin
      mismatched++;
      $display("FAIL down_steps q: got %b expected 1100", q);
    end
  endtask

  task automatic test_shift();
    logic [3:0] pattern;
    logic [3:0] expect_q;
    pattern = 4'b1011;
    expect_q = 4'b0000;
    do_reset();
    en = 1'b1;
    mode = 2'b11;
    for (int n = 3; n >= 0; n--) begin
      ser_in = pattern[n];
      tick();
      expect_q = {expect_q[2:0], pattern[n]};
    end
    compared++;
    if (q !== 4'b1011 || ser_out !== 1'b1) begin
      mismatched++;
      $display("FAIL shift_in q/ser_out: got %b/%b expected 1011/1", q, ser_out);
    end
    ser_in = 1'b0;
    for (int n = 3; n >= 0; n--) begin
      compared++;
      if (ser_out !== pattern[n]) begin
        mismatched++;
        $display("FAIL shift_out ser_out: got %b expected %b", ser_out, pattern[n]);
      end
      tick();
    end
    compared++;
    if (q !== 4'b0000) begin
      mismatched++;
      $display("FAIL shift_flush q: got %b expected 0000", q);
    end
  endtask

  task automatic test_async_reset_mid_count();
    do_reset();
    en = 1'b1;
    mode = 2'b01;
    for (int n = 0; n < 6; n++) tick();
    compared++;
    if (q !== 4'b0110) begin
      mismatched++;
      $display("FAIL midreset_pre q: got %b expected 0110", q);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (q !== 4'b0000) begin
      mismatched++;
      $display("FAIL midreset_async q: got %b expected 0000", q);
    end
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    compared++;
    if (q !== 4'b0011) begin
      mismatched++;
      $display("FAIL midreset_recount q: got %b expected 0011", q);
    end
    mode = 2'b10;
    tick();
    compared++;
    if (q !== 4'b0010) begin
      mismatched++;
      $display("FAIL mode_switch_down q: got %b expected 0010", q);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] mq;
    logic         exp_tc;
    do_reset();
    mq = '0;
    for (int n = 0; n < 300; n++) begin
      en     = ($urandom_range(0, 7) != 0);
      mode   = 2'($urandom_range(0, 3));
      j      = W'($urandom);
      k      = W'($urandom);
      ser_in = 1'($urandom);
      #1;
      exp_tc = model_tc(mq, en, mode);
      compared++;
      if (tc !== exp_tc) begin
        mismatched++;
        $display("FAIL rand_tc cycle %0d: got %b expected %b", n, tc, exp_tc);
      end
      compared++;
      if (ser_out !== mq[W-1]) begin
        mismatched++;
        $display("FAIL rand_ser_out cycle %0d: got %b expected %b", n, ser_out, mq[W-1]);
      end
      mq = model_next(mq, en, mode, j, k, ser_in);
      tick();
      compared++;
      if (q !== mq) begin
        mismatched++;
        $display("FAIL rand_q cycle %0d: got %b expected %b", n, q, mq);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst    = 1'b0;
    en     = 1'b0;
    mode   = 2'b00;
    j      = '0;
    k      = '0;
    ser_in = 1'b0;
    test_reset();
    test_jk_mode();
    test_up_count();
    test_down_count();
    test_shift();
    test_async_reset_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
